// File: rtl/clk_period_meter_pkg.sv
// ----------------------------------------------------------------------------
// clk_meter_pkg
//   Shared definitions for the clock period meter:
//     - default widths / synchronizer depth
//     - measurement FSM state type
//     - small width helper used to size comparisons
// ----------------------------------------------------------------------------
package clk_meter_pkg;

  localparam int unsigned CNT_WIDTH_DEF   = 8;
  localparam int unsigned RATIO_WIDTH_DEF = 5;
  localparam int unsigned SYNC_STAGES_DEF = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } meter_state_t;

  function automatic int unsigned max_width(input int unsigned a,
                                            input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/clk_period_meter_if.sv
// ----------------------------------------------------------------------------
// clk_period_meter_if
//   Control and result bundle of the clock period meter.
//     i_meas_en    level enable for measurement
//     i_exp_ratio  expected division ratio
//     o_period     last measured period (reference clock cycles)
//     o_high       last measured high time (reference clock cycles)
//     o_valid      one-cycle pulse when results update
//     o_match      o_period equals i_exp_ratio (registered with o_valid)
//     o_timeout    sticky: no rising edge within counter range
//   Modports: master = controller side, slave = meter side.
// ----------------------------------------------------------------------------
interface clk_period_meter_if
  import clk_meter_pkg::*;
#(
  parameter int unsigned CNT_WIDTH   = CNT_WIDTH_DEF,
  parameter int unsigned RATIO_WIDTH = RATIO_WIDTH_DEF
) ();

  logic                   i_meas_en;
  logic [RATIO_WIDTH-1:0] i_exp_ratio;
  logic [CNT_WIDTH-1:0]   o_period;
  logic [CNT_WIDTH-1:0]   o_high;
  logic                   o_valid;
  logic                   o_match;
  logic                   o_timeout;

  modport master (
    output i_meas_en,
    output i_exp_ratio,
    input  o_period,
    input  o_high,
    input  o_valid,
    input  o_match,
    input  o_timeout
  );

  modport slave (
    input  i_meas_en,
    input  i_exp_ratio,
    output o_period,
    output o_high,
    output o_valid,
    output o_match,
    output o_timeout
  );

endinterface

// File: rtl/clk_period_meter_sync.sv
// ----------------------------------------------------------------------------
// bit_sync
//   Multi-flop synchronizer for a single asynchronous bit.
//     i_clk  destination clock
//     i_rst  asynchronous active-high reset, clears all stages
//     i_d    asynchronous input
//     o_q    synchronized output (last stage)
// ----------------------------------------------------------------------------
module bit_sync
  import clk_meter_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_d};
    end
  end

  assign o_q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/clk_period_meter.sv
// ----------------------------------------------------------------------------
// clk_period_meter
//   Measures period and high time of a divided clock in reference clock
//   cycles. The divided clock is treated as data: it is synchronized,
//   rising edges are detected, and a counter runs between consecutive rises.
//   Measurement is continuous while enabled; if no rise arrives before the
//   period counter saturates, a sticky timeout is raised and the meter
//   re-arms.
//     i_ref_clk  reference clock (only clock)
//     i_rst      asynchronous active-high reset
//     i_div_clk  divided clock under measurement (asynchronous)
//     mbus       control/result bundle (clk_period_meter_if.slave)
// ----------------------------------------------------------------------------
module clk_period_meter
  import clk_meter_pkg::*;
#(
  parameter int unsigned CNT_WIDTH   = CNT_WIDTH_DEF,
  parameter int unsigned RATIO_WIDTH = RATIO_WIDTH_DEF,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic                 i_ref_clk,
  input  logic                 i_rst,
  input  logic                 i_div_clk,
  clk_period_meter_if.slave    mbus
);

  localparam int unsigned CMP_WIDTH = max_width(CNT_WIDTH, RATIO_WIDTH);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  meter_state_t           state;
  logic                   div_sync;
  logic                   div_prev;
  logic                   rise;
  logic [CNT_WIDTH-1:0]   cnt;
  logic [CNT_WIDTH-1:0]   hcnt;
  logic [CNT_WIDTH-1:0]   period_q;
  logic [CNT_WIDTH-1:0]   high_q;
  logic                   valid_q;
  logic                   match_q;
  logic                   timeout_q;
  logic [CMP_WIDTH-1:0]   cnt_ext;
  logic [CMP_WIDTH-1:0]   ratio_ext;
  logic                   cnt_eq_ratio;
  logic                   cnt_full;

  bit_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .i_clk (i_ref_clk),
    .i_rst (i_rst),
    .i_d   (i_div_clk),
    .o_q   (div_sync)
  );

  // Edge-detect flop on the synchronized level.
  always_ff @(posedge i_ref_clk or posedge i_rst) begin
    if (i_rst) begin
      div_prev <= 1'b0;
    end else begin
      div_prev <= div_sync;
    end
  end

  assign rise = div_sync & ~div_prev;

  // Both operands are zero-extended to a common width so a ratio value that
  // does not fit in the counter can never match.
  assign cnt_ext      = CMP_WIDTH'(cnt);
  assign ratio_ext    = CMP_WIDTH'(mbus.i_exp_ratio);
  assign cnt_eq_ratio = (cnt_ext == ratio_ext);
  assign cnt_full     = &cnt;

  always_ff @(posedge i_ref_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= IDLE;
      cnt       <= '0;
      hcnt      <= '0;
      period_q  <= '0;
      high_q    <= '0;
      valid_q   <= 1'b0;
      match_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (!mbus.i_meas_en) begin
        // Disable overrides everything, including a coincident rise;
        // published results are left untouched.
        state <= IDLE;
        cnt   <= '0;
        hcnt  <= '0;
      end else begin
        case (state)
          IDLE: begin
            cnt   <= '0;
            hcnt  <= '0;
            state <= ARM;
          end

          ARM: begin
            if (rise) begin
              cnt   <= CNT_ONE;
              hcnt  <= CNT_ONE;
              state <= MEASURE;
            end
          end

          MEASURE: begin
            if (rise) begin
              period_q  <= cnt;
              high_q    <= hcnt;
              match_q   <= cnt_eq_ratio;
              valid_q   <= 1'b1;
              timeout_q <= 1'b0;
              cnt       <= CNT_ONE;
              hcnt      <= CNT_ONE;
            end else if (cnt_full) begin
              timeout_q <= 1'b1;
              cnt       <= '0;
              hcnt      <= '0;
              state     <= ARM;
            end else begin
              cnt <= cnt + CNT_ONE;
              if (div_sync) begin
                hcnt <= hcnt + CNT_ONE;
              end
            end
          end

          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

  assign mbus.o_period  = period_q;
  assign mbus.o_high    = high_q;
  assign mbus.o_valid   = valid_q;
  assign mbus.o_match   = match_q;
  assign mbus.o_timeout = timeout_q;

endmodule

// File: tb/tb_clk_period_meter.sv
// ----------------------------------------------------------------------------
// tb_clk_period_meter
//   Drives i_div_clk with directed and random high/low patterns and compares
//   every cycle against a timestamp-based reference: results are derived from
//   the edge index of each accepted rising edge and the recorded level history.
// ----------------------------------------------------------------------------
module tb_clk_period_meter;
  import clk_meter_pkg::*;

  localparam int unsigned CW   = 8;
  localparam int unsigned RW   = 5;
  localparam int          SS   = 2;
  localparam int          MAXC = 40000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic div = 1'b0;

  clk_period_meter_if #(.CNT_WIDTH(CW), .RATIO_WIDTH(RW)) mif ();

  clk_period_meter #(
    .CNT_WIDTH  (CW),
    .RATIO_WIDTH(RW),
    .SYNC_STAGES(SS)
  ) dut (
    .i_ref_clk(clk),
    .i_rst    (rst),
    .i_div_clk(div),
    .mbus     (mif.slave)
  );

  always #5 clk = ~clk;

  int unsigned n_chk = 0;
  int unsigned n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit          lvl [MAXC];
  int          rst_edge = -1;
  bit          on       = 1'b0;
  int          ref_e    = -1;
  int unsigned m_period = 0;
  int unsigned m_high   = 0;
  bit          m_valid  = 1'b0;
  bit          m_match  = 1'b0;
  bit          m_timeout = 1'b0;

  // Level of i_div_clk as sampled at edge k, as seen after reset clearing.
  function automatic bit samp(input int k);
    return (k >= 0 && k > rst_edge) ? lvl[k] : 1'b0;
  endfunction

  task automatic model_step(input int e, input logic r, input logic en,
                            input logic [RW-1:0] ratio, input logic d);
    bit rise_seen;
    if (e < MAXC) lvl[e] = d;
    m_valid = 1'b0;
    if (r) begin
      rst_edge = e; on = 1'b0; ref_e = -1;
      m_period = 0; m_high = 0; m_match = 1'b0; m_timeout = 1'b0;
      return;
    end
    // The meter sees the input SS edges late.
    rise_seen = samp(e - SS) && !samp(e - SS - 1);
    if (!en) begin
      on = 1'b0; ref_e = -1;
    end else if (!on) begin
      on = 1'b1;
    end else if (rise_seen) begin
      if (ref_e >= 0) begin
        m_period = e - ref_e;
        m_high   = 0;
        for (int j = ref_e; j < e; j++) m_high += samp(j - SS);
        m_valid   = 1'b1;
        m_match   = (m_period == int'(ratio));
        m_timeout = 1'b0;
      end
      ref_e = e;
    end else if (ref_e >= 0 && (e - ref_e) == (1 << CW) - 1) begin
      m_timeout = 1'b1;
      ref_e = -1;
    end
  endtask

  int cyc = 0;

  initial begin
    forever begin
      @(posedge clk);
      model_step(cyc, rst, mif.i_meas_en, mif.i_exp_ratio, div);
      #1;
      chk("valid",   mif.o_valid,   m_valid);
      chk("period",  mif.o_period,  m_period);
      chk("high",    mif.o_high,    m_high);
      chk("match",   mif.o_match,   m_match);
      chk("timeout", mif.o_timeout, m_timeout);
      cyc++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic d, input int n);
    repeat (n) begin
      @(negedge clk);
      div = d;
    end
  endtask

  task automatic run_div(input int hi, input int lo, input int periods);
    repeat (periods) begin
      drive(1'b1, hi);
      drive(1'b0, lo);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_period"},  mif.o_period,  0);
    chk({tag, "_high"},    mif.o_high,    0);
    chk({tag, "_valid"},   mif.o_valid,   0);
    chk({tag, "_match"},   mif.o_match,   0);
    chk({tag, "_timeout"}, mif.o_timeout, 0);
  endtask

  int hi, lo;

  initial begin
    mif.i_meas_en   = 1'b0;
    mif.i_exp_ratio = '0;
    repeat (3) @(negedge clk);
    check_all_zero("por");
    rst = 1'b0;
    mif.i_exp_ratio = 5'd4;
    mif.i_meas_en   = 1'b1;

    // divide-by-4, 50% duty
    run_div(2, 2, 10);
    chk("div4_period", mif.o_period, 4);
    chk("div4_high",   mif.o_high,   2);
    chk("div4_match",  mif.o_match,  1);

    // high 3 / low 2 against expected ratio 4
    run_div(3, 2, 8);
    chk("h3l2_period", mif.o_period, 5);
    chk("h3l2_high",   mif.o_high,   3);
    chk("h3l2_match",  mif.o_match,  0);

    // minimum period
    mif.i_exp_ratio = 5'd2;
    run_div(1, 1, 10);
    chk("div2_period", mif.o_period, 2);
    chk("div2_high",   mif.o_high,   1);

    // one rise then a stuck-low input: timeout, then recovery
    drive(1'b1, 2);
    drive(1'b0, 300);
    chk("to_flag", mif.o_timeout, 1);
    mif.i_exp_ratio = 5'd6;
    run_div(3, 3, 3);
    chk("to_rec_period",  mif.o_period,  6);
    chk("to_rec_timeout", mif.o_timeout, 0);
    chk("to_rec_match",   mif.o_match,   1);

    // reset mid-period: outputs clear asynchronously
    mif.i_exp_ratio = 5'd5;
    run_div(3, 2, 4);
    drive(1'b1, 2);
    rst = 1'b1;
    #1;
    check_all_zero("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 2);
    run_div(3, 2, 4);
    drive(1'b1, 1);

    // disable mid-period: results hold, no pulse
    mif.i_meas_en = 1'b0;
    run_div(3, 2, 2);
    chk("dis_period", mif.o_period, 5);
    chk("dis_high",   mif.o_high,   3);
    chk("dis_match",  mif.o_match,  1);
    mif.i_meas_en = 1'b1;

    // disable on the very edge a rise is detected
    run_div(3, 3, 3);
    drive(1'b0, 3);
    drive(1'b1, 2);
    @(negedge clk);
    mif.i_meas_en = 1'b0;
    div = 1'b1;
    @(negedge clk);
    mif.i_meas_en = 1'b1;
    drive(1'b0, 4);

    // constant high: no results beyond the first arm
    drive(1'b1, 280);
    chk("const_hi_timeout", mif.o_timeout, 1);

    // random periods, duty, ratios and enable drops
    repeat (150) begin
      hi = $urandom_range(1, 8);
      lo = $urandom_range(1, 8);
      if ($urandom_range(0, 19) == 0) lo = $urandom_range(245, 265);
      if ($urandom_range(0, 1) == 0) mif.i_exp_ratio = RW'(hi + lo);
      else mif.i_exp_ratio = RW'($urandom_range(0, 31));
      run_div(hi, lo, $urandom_range(1, 4));
      if ($urandom_range(0, 7) == 0) begin
        @(negedge clk);
        mif.i_meas_en = 1'b0;
        drive(div, $urandom_range(1, 3));
        mif.i_meas_en = 1'b1;
      end
    end

    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
